xbar_cfg_arbiter: RTL and testbench

- Arbitrates crossbar-configuration accesses from two requesters: the SPI minion path and the Wishbone slave path.
- Owns the select registers for the input, classifier and output crossbars inside the interconnect.
- Serializes reads and writes with round-robin fairness.
- Rejects writes to any crossbar whose external override pin is asserted.
- Emits a one-cycle update strobe per crossbar on every committed write.

---
 rtl/xbar_cfg_arbiter.sv | 176 +++++++++++++++++
 tb/tb_xbar_cfg_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_cfg_arbiter.sv
// Round-robin arbiter between SPI and Wishbone requesters for the crossbar select registers.
// Optional `XBAR_CFG_LOCK_EN adds a sticky lock register at address NUM_XBARS.
module xbar_cfg_arbiter #(
    parameter int NUM_XBARS = 3,
    parameter int SEL_W     = 4,
    parameter int ADDR_W    = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       spi_req_val,
    output logic                       spi_req_rdy,
    input  logic                       spi_req_we,
    input  logic [ADDR_W-1:0]          spi_req_addr,
    input  logic [SEL_W-1:0]           spi_req_data,
    output logic                       spi_resp_val,
    input  logic                       spi_resp_rdy,
    output logic [SEL_W-1:0]           spi_resp_data,
    output logic                       spi_resp_err,
    input  logic                       wb_req_val,
    output logic                       wb_req_rdy,
    input  logic                       wb_req_we,
    input  logic [ADDR_W-1:0]          wb_req_addr,
    input  logic [SEL_W-1:0]           wb_req_data,
    output logic                       wb_resp_val,
    input  logic                       wb_resp_rdy,
    output logic [SEL_W-1:0]           wb_resp_data,
    output logic                       wb_resp_err,
    input  logic [NUM_XBARS-1:0]       xbar_override,
    output logic [NUM_XBARS*SEL_W-1:0] xbar_cfg,
`ifdef XBAR_CFG_LOCK_EN
    output logic                       cfg_locked,
`endif
    output logic [NUM_XBARS-1:0]       xbar_cfg_upd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state_q, state_d;
    logic                 prio_q, prio_d;   // 0 = SPI has priority, 1 = WB
    logic                 grant_q, grant_d; // 0 = SPI granted, 1 = WB
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [SEL_W-1:0]     data_q, data_d;
    logic [SEL_W-1:0]     cfg_q [NUM_XBARS];
    logic [SEL_W-1:0]     cfg_d [NUM_XBARS];
    logic [NUM_XBARS-1:0] upd_q, upd_d;
    logic [SEL_W-1:0]     rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 lock_q, lock_d;

    logic                 spiWin, wbWin, respRdy;
    logic                 inRange, isLockAddr, ovrHit, accErr;
    logic [SEL_W-1:0]     rdSel, rdVal;

    assign spiWin  = spi_req_val && (!wb_req_val || !prio_q);
    assign wbWin   = wb_req_val && (!spi_req_val || prio_q);
    assign respRdy = grant_q ? wb_resp_rdy : spi_resp_rdy;
    assign inRange = ({1'b0, addr_q} < (ADDR_W+1)'(NUM_XBARS));

    // Decoded lookups avoid indexing past the last crossbar on out-of-range addresses.
    always_comb begin
        rdSel  = '0;
        ovrHit = 1'b0;
        for (int i = 0; i < NUM_XBARS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                rdSel  = cfg_q[i];
                ovrHit = xbar_override[i];
            end
        end
    end

`ifdef XBAR_CFG_LOCK_EN
    assign isLockAddr = ({1'b0, addr_q} == (ADDR_W+1)'(NUM_XBARS));
    assign accErr     = (!inRange && !isLockAddr) || (we_q && lock_q) || (we_q && ovrHit);
    assign rdVal      = isLockAddr ? {{(SEL_W-1){1'b0}}, lock_q} : rdSel;
    assign cfg_locked = lock_q;
`else
    assign isLockAddr = 1'b0;
    assign accErr     = !inRange || (we_q && ovrHit);
    assign rdVal      = rdSel;
`endif

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cfg_d   = cfg_q;
        upd_d   = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (spiWin || wbWin) begin
                    grant_d = wbWin;
                    we_d    = wbWin ? wb_req_we   : spi_req_we;
                    addr_d  = wbWin ? wb_req_addr : spi_req_addr;
                    data_d  = wbWin ? wb_req_data : spi_req_data;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                err_d   = accErr;
                rdata_d = (!we_q && !accErr) ? rdVal : '0;
                if (we_q && !accErr) begin
                    for (int i = 0; i < NUM_XBARS; i++) begin
                        if (addr_q == ADDR_W'(i)) begin
                            cfg_d[i] = data_q;
                            upd_d[i] = 1'b1;
                        end
                    end
                    if (isLockAddr && data_q[0]) begin
                        lock_d = 1'b1;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                if (respRdy) begin
                    prio_d  = !grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            for (int i = 0; i < NUM_XBARS; i++) begin
                cfg_q[i] <= '0;
            end
            upd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            upd_q   <= upd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            lock_q  <= lock_d;
        end
    end

    // Ready is gated by reset so neither requester sees a handshake while held in reset.
    assign spi_req_rdy   = reset && (state_q == IDLE) && spiWin;
    assign wb_req_rdy    = reset && (state_q == IDLE) && wbWin;
    assign spi_resp_val  = (state_q == RESP) && !grant_q;
    assign wb_resp_val   = (state_q == RESP) && grant_q;
    assign spi_resp_data = spi_resp_val ? rdata_q : '0;
    assign wb_resp_data  = wb_resp_val ? rdata_q : '0;
    assign spi_resp_err  = spi_resp_val && err_q;
    assign wb_resp_err   = wb_resp_val && err_q;
    assign xbar_cfg_upd  = upd_q;

    for (genvar g = 0; g < NUM_XBARS; g++) begin : gCfgOut
        assign xbar_cfg[g*SEL_W +: SEL_W] = cfg_q[g];
    end

endmodule

// File: tb/tb_xbar_cfg_arbiter.sv
// Scoreboard bench for xbar_cfg_arbiter: a reference model predicts each response at accept time.
// Build with +define+XBAR_CFG_LOCK_EN to also exercise the lock register.
module tb_xbar_cfg_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        spi_req_val = 1'b0, spi_req_we = 1'b0, spi_resp_rdy = 1'b1;
    logic [1:0]  spi_req_addr = '0;
    logic [3:0]  spi_req_data = '0;
    logic        wb_req_val = 1'b0, wb_req_we = 1'b0, wb_resp_rdy = 1'b1;
    logic [1:0]  wb_req_addr = '0;
    logic [3:0]  wb_req_data = '0;
    logic [2:0]  xbar_override = '0;
    logic        spi_req_rdy, spi_resp_val, spi_resp_err;
    logic        wb_req_rdy, wb_resp_val, wb_resp_err;
    logic [3:0]  spi_resp_data, wb_resp_data;
    logic [11:0] xbar_cfg;
    logic [2:0]  xbar_cfg_upd;
`ifdef XBAR_CFG_LOCK_EN
    logic        cfg_locked;
`endif

    xbar_cfg_arbiter #(.NUM_XBARS(3), .SEL_W(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .spi_req_val(spi_req_val), .spi_req_rdy(spi_req_rdy), .spi_req_we(spi_req_we),
        .spi_req_addr(spi_req_addr), .spi_req_data(spi_req_data),
        .spi_resp_val(spi_resp_val), .spi_resp_rdy(spi_resp_rdy),
        .spi_resp_data(spi_resp_data), .spi_resp_err(spi_resp_err),
        .wb_req_val(wb_req_val), .wb_req_rdy(wb_req_rdy), .wb_req_we(wb_req_we),
        .wb_req_addr(wb_req_addr), .wb_req_data(wb_req_data),
        .wb_resp_val(wb_resp_val), .wb_resp_rdy(wb_resp_rdy),
        .wb_resp_data(wb_resp_data), .wb_resp_err(wb_resp_err),
        .xbar_override(xbar_override), .xbar_cfg(xbar_cfg),
`ifdef XBAR_CFG_LOCK_EN
        .cfg_locked(cfg_locked),
`endif
        .xbar_cfg_upd(xbar_cfg_upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [3:0] data;
        bit         err;
    } exp_t;

    exp_t       sbQueue[$];
    int         testsRun = 0;
    int         testsFailed = 0;
    logic [3:0] modelCfg [3];
    bit         modelPrio = 1'b0;
    bit         modelLock = 1'b0;
    logic [2:0] updStage = '0;
    logic [2:0] updNow = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Predicts the response and register effect of one accepted request.
    task automatic modelAccess(input bit id, input bit we, input logic [1:0] a, input logic [3:0] d);
        exp_t e;
        bit   inR = (a < 2'd3);
        bit   ovr = 1'b0;
        bit   isLock = 1'b0;
        logic [3:0] rd = '0;
        for (int i = 0; i < 3; i++) begin
            if (a == 2'(i)) begin
                ovr = xbar_override[i];
                rd  = modelCfg[i];
            end
        end
`ifdef XBAR_CFG_LOCK_EN
        isLock = (a == 2'd3);
        e.err  = (!inR && !isLock) || (we && modelLock) || (we && ovr);
        if (isLock) rd = {3'b000, modelLock};
`else
        e.err  = !inR || (we && ovr);
`endif
        e.id   = id;
        e.data = (!we && !e.err) ? rd : 4'h0;
        if (we && !e.err) begin
            for (int i = 0; i < 3; i++) begin
                if (a == 2'(i)) begin
                    modelCfg[i] = d;
                    updStage[i] = 1'b1;
                end
            end
            if (isLock && d[0]) modelLock = 1'b1;
        end
        sbQueue.push_back(e);
    endtask

    task automatic checkResp(input bit id, input logic [3:0] d, input bit err);
        exp_t e;
        if (sbQueue.size() == 0) begin
            checkOutput("respUnexpected", 32'(id) + 1, 0);
        end else begin
            e = sbQueue.pop_front();
            checkOutput("respId", 32'(id), 32'(e.id));
            checkOutput("respData", 32'(d), 32'(e.data));
            checkOutput("respErr", 32'(err), 32'(e.err));
            checkOutput("cfgAtResp", 32'(xbar_cfg), 32'({modelCfg[2], modelCfg[1], modelCfg[0]}));
        end
        modelPrio = !id;
    endtask

    // Monitor: arbitration and accept on each edge, responses on handshake, update strobe just after.
    always @(posedge clk) begin
        bit spiAcc, wbAcc, expWb;
        updNow   = updStage;
        updStage = '0;
        if (!reset) begin
            sbQueue.delete();
            for (int i = 0; i < 3; i++) modelCfg[i] = '0;
            modelPrio = 1'b0;
            modelLock = 1'b0;
            updNow    = '0;
        end else begin
            spiAcc = spi_req_val && spi_req_rdy;
            wbAcc  = wb_req_val && wb_req_rdy;
            if (spiAcc || wbAcc) begin
                expWb = (spi_req_val && wb_req_val) ? modelPrio : wb_req_val;
                checkOutput("arbSingleGrant", 32'(spiAcc && wbAcc), 0);
                checkOutput("arbWinner", 32'(wbAcc), 32'(expWb));
                if (wbAcc) modelAccess(1'b1, wb_req_we, wb_req_addr, wb_req_data);
                else       modelAccess(1'b0, spi_req_we, spi_req_addr, spi_req_data);
            end
            checkOutput("respValExclusive", 32'(spi_resp_val && wb_resp_val), 0);
            if (spi_resp_val && spi_resp_rdy) checkResp(1'b0, spi_resp_data, spi_resp_err);
            if (wb_resp_val && wb_resp_rdy)   checkResp(1'b1, wb_resp_data, wb_resp_err);
        end
        #1;
        if (reset) checkOutput("updStrobe", 32'(xbar_cfg_upd), 32'(updNow));
    end

    task automatic waitAccept(input bit isWb);
        int n = 0;
        bit done = 1'b0;
        while (!done) begin
            #1;
            if ((isWb ? wb_req_rdy : spi_req_rdy) == 1'b1) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else if (n >= 100) begin
                checkOutput(isWb ? "acceptTimeoutWb" : "acceptTimeoutSpi", 0, 1);
                done = 1'b1;
            end else begin
                n++;
                @(negedge clk);
            end
        end
        if (isWb) wb_req_val = 1'b0;
        else      spi_req_val = 1'b0;
    endtask

    task automatic driveReq(input bit isWb, input bit we, input logic [1:0] a, input logic [3:0] d);
        if (isWb) begin
            wb_req_val = 1'b1; wb_req_we = we; wb_req_addr = a; wb_req_data = d;
        end else begin
            spi_req_val = 1'b1; spi_req_we = we; spi_req_addr = a; spi_req_data = d;
        end
    endtask

    task automatic applyStimulus(input bit isWb, input bit we, input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        driveReq(isWb, we, a, d);
        waitAccept(isWb);
    endtask

    task automatic waitDone();
        int n = 0;
        @(negedge clk);
        while (sbQueue.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbQueue.size() != 0) checkOutput("respTimeout", 32'(sbQueue.size()), 0);
        @(negedge clk);
    endtask

    task automatic applyReset(input int cycles);
        @(negedge clk);
        reset = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Reset with both requesters pending; SPI must win first after release.
        driveReq(1'b0, 1'b0, 2'd0, 4'h0);
        driveReq(1'b1, 1'b0, 2'd1, 4'h0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rstSpiRdy", 32'(spi_req_rdy), 0);
        checkOutput("rstWbRdy", 32'(wb_req_rdy), 0);
        checkOutput("rstCfg", 32'(xbar_cfg), 0);
        checkOutput("rstUpd", 32'(xbar_cfg_upd), 0);
        checkOutput("rstRespVal", 32'({spi_resp_val, wb_resp_val}), 0);
        reset = 1'b1;
        #1;
        checkOutput("firstSpiRdy", 32'(spi_req_rdy), 1);
        checkOutput("firstWbRdy", 32'(wb_req_rdy), 0);
        fork
            waitAccept(1'b0);
            waitAccept(1'b1);
        join
        waitDone();

        // Write then read back crossbar 1.
        applyStimulus(1'b0, 1'b1, 2'd1, 4'h5);
        @(posedge clk);
        #1;
        checkOutput("wrCfgAfterE1", 32'(xbar_cfg[7:4]), 32'h5);
        checkOutput("wrRespVal", 32'(spi_resp_val), 1);
        checkOutput("wrRespErr", 32'(spi_resp_err), 0);
        waitDone();
        applyStimulus(1'b0, 1'b0, 2'd1, 4'h0);
        waitDone();
        applyStimulus(1'b1, 1'b0, 2'd1, 4'h0);
        waitDone();

        // Simultaneous writes, pointer at SPI then at WB.
        fork
            applyStimulus(1'b0, 1'b1, 2'd0, 4'h3);
            applyStimulus(1'b1, 1'b1, 2'd0, 4'hA);
        join
        waitDone();
        checkOutput("rrRound1", 32'(xbar_cfg[3:0]), 32'hA);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0);
        waitDone();
        fork
            applyStimulus(1'b0, 1'b1, 2'd0, 4'h1);
            applyStimulus(1'b1, 1'b1, 2'd0, 4'h2);
        join
        waitDone();
        checkOutput("rrRound2", 32'(xbar_cfg[3:0]), 32'h1);

        // Error paths: out-of-range address and override-blocked write.
`ifndef XBAR_CFG_LOCK_EN
        applyStimulus(1'b1, 1'b1, 2'd3, 4'h9);
        waitDone();
        checkOutput("oorCfg", 32'(xbar_cfg), 32'h051);
`endif
        xbar_override = 3'b001;
        applyStimulus(1'b0, 1'b1, 2'd0, 4'hF);
        waitDone();
        checkOutput("ovrCfg", 32'(xbar_cfg[3:0]), 32'h1);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0);
        waitDone();
        xbar_override = 3'b000;

        // Back-pressure on the SPI response, then reset mid-response.
        spi_resp_rdy = 1'b0;
        applyStimulus(1'b0, 1'b1, 2'd2, 4'h6);
        wb_req_val = 1'b1; wb_req_we = 1'b0; wb_req_addr = 2'd0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("holdSpiRespVal", 32'(spi_resp_val), 1);
            checkOutput("holdWbRdy", 32'(wb_req_rdy), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("midRstRespVal", 32'(spi_resp_val), 0);
        checkOutput("midRstCfg", 32'(xbar_cfg), 0);
        wb_req_val = 1'b0;
        spi_resp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;

`ifdef XBAR_CFG_LOCK_EN
        applyStimulus(1'b0, 1'b1, 2'd3, 4'h1);
        waitDone();
        checkOutput("lockSet", 32'(cfg_locked), 1);
        applyStimulus(1'b1, 1'b1, 2'd2, 4'h7);
        waitDone();
        checkOutput("lockedCfg", 32'(xbar_cfg), 0);
        applyStimulus(1'b0, 1'b0, 2'd3, 4'h0);
        waitDone();
        applyReset(2);
        #1;
        checkOutput("lockCleared", 32'(cfg_locked), 0);
`endif

        // Normal operation after reset.
        applyStimulus(1'b1, 1'b1, 2'd2, 4'hC);
        waitDone();
        applyStimulus(1'b1, 1'b0, 2'd2, 4'h0);
        waitDone();
        checkOutput("postRstCfg", 32'(xbar_cfg), 32'hC00);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        testsFailed++;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
